// File: rtl/uart_rx_cmd_parser_if.sv
// uart_rx_cmd_parser_if
// Bundles the byte stream from the UART receiver, the command handshake
// toward the system controller, and the error pulses into one interface.
//
// Signals:
//   RX_P_DATA   received byte, valid while RX_D_VLD is high
//   RX_D_VLD    one-cycle pulse per error-free received byte
//   RX_PAR_ERR  receiver parity error flag
//   RX_STP_ERR  receiver stop-bit error flag
//   CMD_VALID   assembled command word is valid
//   CMD_READY   consumer accepts the command word
//   CMD_TYPE    00 WR, 01 RD, 10 ALU_OP, 11 ALU_NOP
//   CMD_ADDR    register address (WR/RD)
//   CMD_OPA     write data (WR) or operand A (ALU_OP)
//   CMD_OPB     operand B (ALU_OP)
//   CMD_FUN     ALU function (ALU_OP/ALU_NOP)
//   FRAME_ERR   one-cycle pulse when a frame is discarded
//   ERR_CAUSE   01 bad opcode, 10 line error, 11 timeout
//   OVERRUN     one-cycle pulse when a byte is dropped while a command waits
//
// Modports:
//   master  the parser side (consumes RX, produces CMD/error outputs)
//   slave   the environment side (produces RX and CMD_READY)

interface uart_rx_cmd_parser_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  RX_PAR_ERR;
  logic                  RX_STP_ERR;
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [1:0]            CMD_TYPE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_OPA;
  logic [DATA_WIDTH-1:0] CMD_OPB;
  logic [3:0]            CMD_FUN;
  logic                  FRAME_ERR;
  logic [1:0]            ERR_CAUSE;
  logic                  OVERRUN;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR, CMD_READY,
    output CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_OPA, CMD_OPB, CMD_FUN,
           FRAME_ERR, ERR_CAUSE, OVERRUN
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR, CMD_READY,
    input  CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_OPA, CMD_OPB, CMD_FUN,
           FRAME_ERR, ERR_CAUSE, OVERRUN
  );

endinterface

// File: rtl/uart_rx_cmd_parser.sv
// uart_rx_cmd_parser
// Assembles multi-byte command frames received from a UART into one
// registered command word and offers it to the system controller with a
// valid/ready handshake. Malformed, line-corrupted, overrun and (optionally)
// timed-out frames are flagged with single-cycle pulses.
//
// Frames (first byte is the opcode):
//   AA ADDR DATA      -> WR
//   BB ADDR           -> RD
//   CC OPA OPB FUN    -> ALU_OP
//   DD FUN            -> ALU_NOP
//
// Ports:
//   CLK   clock of the receiver domain
//   RST   asynchronous active-high reset
//   bus   uart_rx_cmd_parser_if.master (RX byte stream, command word,
//         handshake and error pulses)
//
// Optional feature macro: CMD_TIMEOUT_EN
//   When defined, a partial frame that sees no byte for TIMEOUT_CYCLES
//   cycles is discarded with ERR_CAUSE 11. When undefined no timer exists
//   and a partial frame waits indefinitely.

module uart_rx_cmd_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                  CLK,
  input logic                  RST,
  uart_rx_cmd_parser_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    GET_B1,
    GET_B2,
    GET_B3,
    HOLD
  } state_t;

  localparam logic [1:0] TYPE_WR  = 2'b00;
  localparam logic [1:0] TYPE_RD  = 2'b01;
  localparam logic [1:0] TYPE_ALU = 2'b10;
  localparam logic [1:0] TYPE_NOP = 2'b11;

  localparam logic [1:0] CAUSE_OPCODE  = 2'b01;
  localparam logic [1:0] CAUSE_LINE    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_NOP = DATA_WIDTH'(8'hDD);

  state_t                state_q, state_d;
  logic [1:0]            cmd_type_q, cmd_type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [3:0]            fun_q, fun_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            cause_q, cause_d;
  logic                  overrun_q, overrun_d;

  logic                  line_err;
  logic                  timeout_hit;
  logic                  start_frame;

  assign line_err = bus.RX_PAR_ERR | bus.RX_STP_ERR;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] timer_q;
  logic          in_get;

  assign in_get      = (state_q == GET_B1) || (state_q == GET_B2) || (state_q == GET_B3);
  // A byte arriving in the expiry cycle keeps the frame alive.
  assign timeout_hit = in_get && !bus.RX_D_VLD && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Inter-byte timer: counts idle cycles inside a partial frame and
  // restarts on every received byte or whenever the FSM heads to IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_q <= '0;
    end else if (!in_get || bus.RX_D_VLD || state_d == IDLE) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State and command-word registers; every output comes straight from here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cmd_type_q  <= '0;
      addr_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      cause_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_type_q  <= cmd_type_d;
      addr_q      <= addr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      fun_q       <= fun_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      cause_q     <= cause_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state and next-field logic. Fields are kept at zero outside an
  // active frame, so clearing them on abort or handshake is what makes
  // unused fields of a completed command read as zero. An opcode is decoded
  // both from IDLE and from HOLD in the handshake cycle, so the decode sits
  // after the state case and is triggered through start_frame.
  always_comb begin
    state_d     = state_q;
    cmd_type_d  = cmd_type_q;
    addr_d      = addr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    fun_d       = fun_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    cause_d     = cause_q;
    overrun_d   = 1'b0;
    start_frame = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_frame = bus.RX_D_VLD;
      end

      GET_B1, GET_B2, GET_B3: begin
        if (line_err || timeout_hit) begin
          state_d     = IDLE;
          cmd_type_d  = '0;
          addr_d      = '0;
          opa_d       = '0;
          opb_d       = '0;
          fun_d       = '0;
          frame_err_d = 1'b1;
          cause_d     = line_err ? CAUSE_LINE : CAUSE_TIMEOUT;
        end else if (bus.RX_D_VLD) begin
          if (state_q == GET_B1) begin
            unique case (cmd_type_q)
              TYPE_WR: begin
                addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = GET_B2;
              end
              TYPE_RD: begin
                addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = HOLD;
                valid_d = 1'b1;
              end
              TYPE_ALU: begin
                opa_d   = bus.RX_P_DATA;
                state_d = GET_B2;
              end
              default: begin
                fun_d   = bus.RX_P_DATA[3:0];
                state_d = HOLD;
                valid_d = 1'b1;
              end
            endcase
          end else if (state_q == GET_B2) begin
            if (cmd_type_q == TYPE_WR) begin
              opa_d   = bus.RX_P_DATA;
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              opb_d   = bus.RX_P_DATA;
              state_d = GET_B3;
            end
          end else begin
            fun_d   = bus.RX_P_DATA[3:0];
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (bus.CMD_READY) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          cmd_type_d  = '0;
          addr_d      = '0;
          opa_d       = '0;
          opb_d       = '0;
          fun_d       = '0;
          start_frame = bus.RX_D_VLD;
        end else if (bus.RX_D_VLD) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_frame) begin
      unique case (bus.RX_P_DATA)
        OP_WR: begin
          cmd_type_d = TYPE_WR;
          state_d    = GET_B1;
        end
        OP_RD: begin
          cmd_type_d = TYPE_RD;
          state_d    = GET_B1;
        end
        OP_ALU: begin
          cmd_type_d = TYPE_ALU;
          state_d    = GET_B1;
        end
        OP_NOP: begin
          cmd_type_d = TYPE_NOP;
          state_d    = GET_B1;
        end
        default: begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cause_d     = CAUSE_OPCODE;
        end
      endcase
    end
  end

  assign bus.CMD_VALID = valid_q;
  assign bus.CMD_TYPE  = cmd_type_q;
  assign bus.CMD_ADDR  = addr_q;
  assign bus.CMD_OPA   = opa_q;
  assign bus.CMD_OPB   = opb_q;
  assign bus.CMD_FUN   = fun_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.ERR_CAUSE = cause_q;
  assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// tb_uart_rx_cmd_parser
// Self-checking bench for uart_rx_cmd_parser. Directed scenarios from the
// frame rules plus randomized frames compared against a frame-level model.
// Build with +define+CMD_TIMEOUT_EN to also exercise the inter-byte timeout.

module tb_uart_rx_cmd_parser;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_rx_cmd_parser_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_rx_cmd_parser #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Observed command word {VALID, TYPE, ADDR, OPA, OPB, FUN}
  function automatic logic [26:0] cmd_now();
    return {bus.CMD_VALID, bus.CMD_TYPE, bus.CMD_ADDR, bus.CMD_OPA, bus.CMD_OPB, bus.CMD_FUN};
  endfunction

  // Observed error bundle {FRAME_ERR, ERR_CAUSE, OVERRUN}
  function automatic logic [3:0] err_now();
    return {bus.FRAME_ERR, bus.ERR_CAUSE, bus.OVERRUN};
  endfunction

  // Reference: the command word a complete frame must produce
  function automatic logic [26:0] expect_cmd(input logic [7:0] op, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    logic [3:0] lo1;
    logic [3:0] lo3;
    lo1 = 4'(b1 % 16);
    lo3 = 4'(b3 % 16);
    case (op)
      8'hAA:   return {1'b1, 2'd0, lo1, b2, 8'h00, 4'h0};
      8'hBB:   return {1'b1, 2'd1, lo1, 8'h00, 8'h00, 4'h0};
      8'hCC:   return {1'b1, 2'd2, 4'h0, b1, b2, lo3};
      8'hDD:   return {1'b1, 2'd3, 4'h0, 8'h00, 8'h00, lo1};
      default: return 27'd0;
    endcase
  endfunction

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 1;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    tick(1);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic line_error(input logic par, input logic stp, input logic vld, input logic [7:0] b);
    bus.RX_P_DATA  = b;
    bus.RX_D_VLD   = vld;
    bus.RX_PAR_ERR = par;
    bus.RX_STP_ERR = stp;
    tick(1);
    bus.RX_D_VLD   = 1'b0;
    bus.RX_PAR_ERR = 1'b0;
    bus.RX_STP_ERR = 1'b0;
  endtask

  task automatic handshake();
    bus.CMD_READY = 1'b1;
    tick(1);
    bus.CMD_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(2);
    checks++;
    if (cmd_now() !== 27'd0) begin
      failures++;
      $display("FAIL reset_cmd got=%h exp=%h", cmd_now(), 27'd0);
    end
    checks++;
    if (err_now() !== 4'd0) begin
      failures++;
      $display("FAIL reset_err got=%h exp=%h", err_now(), 4'd0);
    end
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_write();
    bus.CMD_READY = 1'b1;
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    checks++;
    if (cmd_now() !== expect_cmd(8'hAA, 8'h05, 8'h3C, 8'h00)) begin
      failures++;
      $display("FAIL wr_cmd got=%h exp=%h", cmd_now(), expect_cmd(8'hAA, 8'h05, 8'h3C, 8'h00));
    end
    tick(1);
    checks++;
    if (cmd_now() !== 27'd0) begin
      failures++;
      $display("FAIL wr_drop got=%h exp=%h", cmd_now(), 27'd0);
    end
    bus.CMD_READY = 1'b0;
  endtask

  task automatic test_alu_hold();
    logic [26:0] exp;
    exp = expect_cmd(8'hCC, 8'h12, 8'h34, 8'h07);
    send_byte(8'hCC);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h07);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (cmd_now() !== exp) begin
        failures++;
        $display("FAIL alu_hold[%0d] got=%h exp=%h", i, cmd_now(), exp);
      end
      tick(1);
    end
    handshake();
    checks++;
    if (cmd_now() !== 27'd0) begin
      failures++;
      $display("FAIL alu_release got=%h exp=%h", cmd_now(), 27'd0);
    end
    tick(1);
    checks++;
    if (bus.CMD_VALID !== 1'b0) begin
      failures++;
      $display("FAIL alu_single got=%b exp=%b", bus.CMD_VALID, 1'b0);
    end
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h5A);
    checks++;
    if (err_now() !== 4'b1010 || bus.CMD_VALID !== 1'b0) begin
      failures++;
      $display("FAIL bad_op got=%h/%b exp=%h/%b", err_now(), bus.CMD_VALID, 4'b1010, 1'b0);
    end
    tick(1);
    checks++;
    if (err_now() !== 4'b0010) begin
      failures++;
      $display("FAIL bad_op_pulse got=%h exp=%h", err_now(), 4'b0010);
    end
    send_byte(8'hBB);
    send_byte(8'h03);
    checks++;
    if (cmd_now() !== expect_cmd(8'hBB, 8'h03, 8'h00, 8'h00)) begin
      failures++;
      $display("FAIL rd_cmd got=%h exp=%h", cmd_now(), expect_cmd(8'hBB, 8'h03, 8'h00, 8'h00));
    end
    handshake();
  endtask

  task automatic test_line_error();
    send_byte(8'hBB);
    line_error(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (err_now() !== 4'b1100 || cmd_now() !== 27'd0) begin
      failures++;
      $display("FAIL stp_abort got=%h/%h exp=%h/%h", err_now(), cmd_now(), 4'b1100, 27'd0);
    end
    send_byte(8'hDD);
    send_byte(8'h02);
    checks++;
    if (cmd_now() !== expect_cmd(8'hDD, 8'h02, 8'h00, 8'h00)) begin
      failures++;
      $display("FAIL nop_cmd got=%h exp=%h", cmd_now(), expect_cmd(8'hDD, 8'h02, 8'h00, 8'h00));
    end
    handshake();
    // the byte must lose to a simultaneous error flag
    send_byte(8'hBB);
    line_error(1'b1, 1'b0, 1'b1, 8'h03);
    checks++;
    if (err_now() !== 4'b1100 || bus.CMD_VALID !== 1'b0) begin
      failures++;
      $display("FAIL err_wins got=%h/%b exp=%h/%b", err_now(), bus.CMD_VALID, 4'b1100, 1'b0);
    end
    // error flags in IDLE are ignored
    line_error(1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (bus.FRAME_ERR !== 1'b0) begin
      failures++;
      $display("FAIL idle_err got=%b exp=%b", bus.FRAME_ERR, 1'b0);
    end
  endtask

  task automatic test_overrun();
    logic [26:0] exp;
    exp = expect_cmd(8'hDD, 8'h01, 8'h00, 8'h00);
    send_byte(8'hDD);
    send_byte(8'h01);
    send_byte(8'h77);
    checks++;
    if ({bus.FRAME_ERR, bus.OVERRUN} !== 2'b01 || cmd_now() !== exp) begin
      failures++;
      $display("FAIL overrun got=%b%b/%h exp=01/%h", bus.FRAME_ERR, bus.OVERRUN, cmd_now(), exp);
    end
    line_error(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.FRAME_ERR !== 1'b0 || bus.OVERRUN !== 1'b0 || cmd_now() !== exp) begin
      failures++;
      $display("FAIL hold_err got=%b%b/%h exp=00/%h", bus.FRAME_ERR, bus.OVERRUN, cmd_now(), exp);
    end
    bus.CMD_READY = 1'b1;
    send_byte(8'hAA);
    bus.CMD_READY = 1'b0;
    checks++;
    if (bus.CMD_VALID !== 1'b0 || bus.OVERRUN !== 1'b0 || bus.FRAME_ERR !== 1'b0) begin
      failures++;
      $display("FAIL hs_with_byte got=%b%b%b exp=000", bus.CMD_VALID, bus.OVERRUN, bus.FRAME_ERR);
    end
    send_byte(8'h05);
    send_byte(8'h3C);
    checks++;
    if (cmd_now() !== expect_cmd(8'hAA, 8'h05, 8'h3C, 8'h00)) begin
      failures++;
      $display("FAIL hs_new_wr got=%h exp=%h", cmd_now(), expect_cmd(8'hAA, 8'h05, 8'h3C, 8'h00));
    end
    handshake();
  endtask

  task automatic test_random();
    logic [7:0]  fb[4];
    logic [7:0]  ops[4];
    logic [26:0] exp;
    logic [1:0]  e;
    int          len;
    int          abort_at;
    logic        aborted;
    ops[0] = 8'hAA;
    ops[1] = 8'hBB;
    ops[2] = 8'hCC;
    ops[3] = 8'hDD;
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      if (kind < 4) begin
        fb[0] = ops[kind];
      end else begin
        fb[0] = 8'($urandom_range(0, 255));
        while (fb[0] == 8'hAA || fb[0] == 8'hBB || fb[0] == 8'hCC || fb[0] == 8'hDD)
          fb[0] = 8'($urandom_range(0, 255));
      end
      for (int k = 1; k < 4; k++) fb[k] = 8'($urandom_range(0, 255));
      len      = frame_len(fb[0]);
      abort_at = (len > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      exp      = expect_cmd(fb[0], fb[1], fb[2], fb[3]);
      aborted  = 1'b0;
      tick(int'($urandom_range(0, 3)));
      send_byte(fb[0]);
      if (len == 1) begin
        checks++;
        if (err_now() !== 4'b1010 || bus.CMD_VALID !== 1'b0) begin
          failures++;
          $display("FAIL rnd_bad_op[%0d] got=%h exp=%h", n, err_now(), 4'b1010);
        end
        continue;
      end
      for (int i = 1; i < len; i++) begin
        tick(int'($urandom_range(0, 3)));
        if (i == abort_at) begin
          e = 2'($urandom_range(1, 3));
          line_error(e[0], e[1], 1'($urandom_range(0, 1)), fb[i]);
          checks++;
          if (err_now() !== 4'b1100 || cmd_now() !== 27'd0) begin
            failures++;
            $display("FAIL rnd_abort[%0d] got=%h/%h exp=%h/%h", n, err_now(), cmd_now(), 4'b1100, 27'd0);
          end
          aborted = 1'b1;
          break;
        end
        send_byte(fb[i]);
      end
      if (aborted) continue;
      checks++;
      if (cmd_now() !== exp) begin
        failures++;
        $display("FAIL rnd_cmd[%0d] got=%h exp=%h", n, cmd_now(), exp);
      end
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) begin
          send_byte(8'($urandom_range(0, 255)));
          checks++;
          if (bus.OVERRUN !== 1'b1 || bus.FRAME_ERR !== 1'b0 || cmd_now() !== exp) begin
            failures++;
            $display("FAIL rnd_overrun[%0d] got=%b%b/%h exp=10/%h", n, bus.OVERRUN, bus.FRAME_ERR, cmd_now(), exp);
          end
        end else begin
          tick(1);
          checks++;
          if (bus.OVERRUN !== 1'b0 || cmd_now() !== exp) begin
            failures++;
            $display("FAIL rnd_hold[%0d] got=%b/%h exp=0/%h", n, bus.OVERRUN, cmd_now(), exp);
          end
        end
      end
      handshake();
      checks++;
      if (cmd_now() !== 27'd0) begin
        failures++;
        $display("FAIL rnd_release[%0d] got=%h exp=%h", n, cmd_now(), 27'd0);
      end
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    send_byte(8'hAA);
    send_byte(8'h05);
    for (int i = 1; i < TO; i++) begin
      tick(1);
      checks++;
      if (bus.FRAME_ERR !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early[%0d] got=%b exp=%b", i, bus.FRAME_ERR, 1'b0);
      end
    end
    tick(1);
    checks++;
    if (err_now() !== 4'b1110 || cmd_now() !== 27'd0) begin
      failures++;
      $display("FAIL timeout got=%h/%h exp=%h/%h", err_now(), cmd_now(), 4'b1110, 27'd0);
    end
    // a byte in the last cycle before expiry keeps the frame alive
    send_byte(8'hBB);
    tick(TO - 1);
    send_byte(8'h09);
    checks++;
    if (bus.FRAME_ERR !== 1'b0 || cmd_now() !== expect_cmd(8'hBB, 8'h09, 8'h00, 8'h00)) begin
      failures++;
      $display("FAIL timeout_byte_wins got=%b/%h exp=0/%h", bus.FRAME_ERR, cmd_now(),
               expect_cmd(8'hBB, 8'h09, 8'h00, 8'h00));
    end
    handshake();
  endtask
`endif

  task automatic test_reset_midframe();
    send_byte(8'h5A);
    send_byte(8'hCC);
    send_byte(8'h44);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (cmd_now() !== 27'd0 || err_now() !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h/%h exp=%h/%h", cmd_now(), err_now(), 27'd0, 4'd0);
    end
    tick(1);
    RST = 1'b0;
    tick(1);
    send_byte(8'hDD);
    send_byte(8'h0B);
    checks++;
    if (cmd_now() !== expect_cmd(8'hDD, 8'h0B, 8'h00, 8'h00)) begin
      failures++;
      $display("FAIL after_reset got=%h exp=%h", cmd_now(), expect_cmd(8'hDD, 8'h0B, 8'h00, 8'h00));
    end
    handshake();
  endtask

  initial begin
    RST            = 1'b1;
    bus.RX_P_DATA  = '0;
    bus.RX_D_VLD   = 1'b0;
    bus.RX_PAR_ERR = 1'b0;
    bus.RX_STP_ERR = 1'b0;
    bus.CMD_READY  = 1'b0;
    test_reset();
    test_write();
    test_alu_hold();
    test_bad_opcode();
    test_line_error();
    test_overrun();
    test_random();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_parser.md
Name: uart_rx_cmd_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream (P_DATA / DATA_VALID / Parity_Error / Stop_Error). Assembles multi-byte command frames (register write, register read, ALU with operands, ALU without operands) into one registered command word. Presents that word to the system controller with a valid/ready handshake. Flags malformed, corrupted, overrun and (optionally) timed-out frames.

Parameters:
DATA_WIDTH, 8, width of a received byte and of operand/data fields
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
TIMEOUT_CYCLES, 4096, inter-byte timeout in CLK cycles (used only with CMD_TIMEOUT_EN)

Ports:
CLK  input  1  receiver clock domain clock
RST  input  1  asynchronous, active-high reset
RX_P_DATA  input  DATA_WIDTH  received byte, valid when RX_D_VLD=1
RX_D_VLD  input  1  one-cycle pulse per error-free received byte
RX_PAR_ERR  input  1  parity error flag from receiver
RX_STP_ERR  input  1  stop error flag from receiver
CMD_VALID  output  1  command word valid
CMD_READY  input  1  consumer accepts command
CMD_TYPE  output  2  00 WR, 01 RD, 10 ALU_OP, 11 ALU_NOP
CMD_ADDR  output  ADDR_WIDTH  register address (WR/RD)
CMD_OPA  output  DATA_WIDTH  write data (WR) or operand A (ALU_OP)
CMD_OPB  output  DATA_WIDTH  operand B (ALU_OP)
CMD_FUN  output  4  ALU function (ALU_OP/ALU_NOP), low nibble of function byte
FRAME_ERR  output  1  one-cycle pulse: frame discarded
ERR_CAUSE  output  2  cause latched with FRAME_ERR: 01 bad opcode, 10 line error, 11 timeout; holds until next FRAME_ERR
OVERRUN  output  1  one-cycle pulse: byte dropped while command pending

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; byte counter and timeout counter 0.
- Frame formats (first byte is opcode):
  - 0xAA: ADDR, DATA -> WR (3 bytes)
  - 0xBB: ADDR -> RD (2 bytes)
  - 0xCC: OPA, OPB, FUN -> ALU_OP (4 bytes)
  - 0xDD: FUN -> ALU_NOP (2 bytes)
- FSM states: IDLE, GET_B1, GET_B2, GET_B3, HOLD.
  - IDLE + RX_D_VLD with a valid opcode: latch type; go to GET_B1.
  - IDLE + RX_D_VLD with any other opcode: FRAME_ERR, cause 01; stay in IDLE.
  - GET_Bn + RX_D_VLD: store the byte into its field; go to GET_Bn+1, or to HOLD when it is the last byte of the frame type.
  - Entering HOLD: CMD_VALID=1 in the cycle after the final byte's RX_D_VLD (latency 1).
- Fields not used by a command type drive 0 (e.g. RD: OPA=OPB=FUN=0).
- Handshake:
  - CMD_VALID and all CMD_* fields stay stable until a cycle with CMD_VALID&CMD_READY.
  - After that cycle: CMD_VALID=0, fields cleared to 0, state IDLE.
- In HOLD without handshake, RX_D_VLD: byte dropped, OVERRUN pulse, state unchanged.
- In HOLD with handshake and RX_D_VLD in the same cycle: byte is processed as an IDLE opcode; no OVERRUN.
- RX_PAR_ERR or RX_STP_ERR high in any GET_Bn state: frame aborted, FRAME_ERR with cause 10, go to IDLE, partial fields discarded.
- Error flag in IDLE: ignored.
- Error flag in HOLD: ignored; the pending command is preserved.
- Error flag and RX_D_VLD in the same cycle: the error wins.
- FRAME_ERR and OVERRUN are single-cycle pulses and are never asserted together.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES)+1) runs while in GET_B1..GET_B3.
  - It clears on each RX_D_VLD and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no byte received: FRAME_ERR with cause 11, go to IDLE.
  - If a byte arrives in the same cycle as expiry, the byte wins and the counter clears.
- Undefined: no counter is built; a partial frame waits indefinitely; cause 11 never occurs.

Test Plan:
- Bytes AA,05,3C with CMD_READY=1 -> CMD_VALID one cycle after 3C; TYPE=00, ADDR=5, OPA=3C; dropped next cycle.
- Bytes CC,12,34,07 with CMD_READY=0 for 20 cycles, then 1 -> fields stable (TYPE=10, OPA=12, OPB=34, FUN=7) for 20 cycles; one handshake.
- Byte 5A in IDLE -> FRAME_ERR pulse, ERR_CAUSE=01, no CMD_VALID; then BB,03 -> RD with ADDR=3.
- BB then RX_STP_ERR pulse -> FRAME_ERR with cause 10, IDLE; then DD,02 -> ALU_NOP with FUN=2.
- DD,01 pending (READY=0), byte 77 arrives -> OVERRUN pulse, command unchanged; READY=1 together with RX_D_VLD of AA -> handshake, new WR frame started.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: AA,05 then silence -> FRAME_ERR with cause 11 exactly 16 cycles after 05; RST asserted mid-frame -> all outputs 0 immediately.
